// File: rtl/div_pkg.sv
// Shared FSM state, error codes and saturation patterns for the fixed-point divide controller.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ARM,
    WAIT,
    OUT
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_DIVZ    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // Held at 64 bits; a user of width W takes the top W bits, which keeps the sign pattern.
  localparam logic [63:0] SAT_POS = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SAT_NEG = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/div_if.sv
// Request, divider and result channels of the divide controller.
interface div_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_n;
  logic [WIDTH-1:0] in_d;
  logic [TAG_W-1:0] in_tag;

  logic [WIDTH-1:0] div_n;
  logic [WIDTH-1:0] div_d;
  logic             div_start;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;
  logic             div_done;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_r;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       out_err;

  modport slave (
    input  in_valid, in_n, in_d, in_tag, div_q, div_r, div_done, out_ready,
    output in_ready, div_n, div_d, div_start, out_valid, out_q, out_r, out_tag, out_err
  );

  modport master (
    output in_valid, in_n, in_d, in_tag, div_q, div_r, div_done, out_ready,
    input  in_ready, div_n, div_d, div_start, out_valid, out_q, out_r, out_tag, out_err
  );
endinterface

// File: rtl/div_req_fifo.sv
// Synchronous show-ahead request FIFO; full and empty are told apart by an explicit count.
module div_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of 2, so pointer wrap is the natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/div_ctrl.sv
// Front end for an external fixed-point divider: queues tagged requests, issues one division
// at a time, handles divide-by-zero and timeout, and holds each result until it is taken.
module div_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FRAC    = 16,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input logic  clk,
  input logic  rst_n,
  div_if.slave bus
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("div_ctrl: DEPTH must be a power of 2 and at least 2");
  end
  if (FRAC < 0 || FRAC >= WIDTH || WIDTH > 64) begin : g_bad_fmt
    $error("div_ctrl: need 0 <= FRAC < WIDTH <= 64");
  end
  if (TIMEOUT < 1) begin : g_bad_tmo
    $error("div_ctrl: TIMEOUT must be at least 1");
  end

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] Q_POS = SAT_POS[63 -: WIDTH];
  localparam logic [WIDTH-1:0] Q_NEG = SAT_NEG[63 -: WIDTH];

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] d;
  } req_t;

  req_t             req_in, head;
  logic             fifo_full, fifo_empty, push, pop;
  state_t           state;
  logic [WIDTH-1:0] opn, opd;
  logic [TAG_W-1:0] op_tag;
  logic             start_r;
  logic [TMO_W-1:0] tmo;
  logic             ov_r;
  logic [WIDTH-1:0] q_r, r_r;
  logic [TAG_W-1:0] tag_r;
  logic [1:0]       err_r;

  assign req_in       = '{tag: bus.in_tag, n: bus.in_n, d: bus.in_d};
  assign bus.in_ready = rst_n && !fifo_full;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state == IDLE) && !fifo_empty;

  div_req_fifo #(
    .W    ($bits(req_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .din  (req_in),
    .pop  (pop),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign bus.div_n     = opn;
  assign bus.div_d     = opd;
  assign bus.div_start = start_r;
  assign bus.out_valid = ov_r;
  assign bus.out_q     = q_r;
  assign bus.out_r     = r_r;
  assign bus.out_tag   = tag_r;
  assign bus.out_err   = err_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      opn     <= '0;
      opd     <= '0;
      op_tag  <= '0;
      start_r <= 1'b0;
      tmo     <= '0;
      ov_r    <= 1'b0;
      q_r     <= '0;
      r_r     <= '0;
      tag_r   <= '0;
      err_r   <= ERR_OK;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            if (head.d == '0) begin
              ov_r  <= 1'b1;
              q_r   <= head.n[WIDTH-1] ? Q_NEG : Q_POS;
              r_r   <= '0;
              tag_r <= head.tag;
              err_r <= ERR_DIVZ;
              state <= OUT;
            end else begin
              opn     <= head.n;
              opd     <= head.d;
              op_tag  <= head.tag;
              start_r <= 1'b1;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          start_r <= 1'b0;
          state   <= ARM;
        end
        // div_done is not looked at here: it may still be high from the previous division.
        ARM: begin
          tmo   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (bus.div_done) begin
            ov_r  <= 1'b1;
            q_r   <= bus.div_q;
            r_r   <= bus.div_r;
            tag_r <= op_tag;
            err_r <= ERR_OK;
            state <= OUT;
          end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
            ov_r  <= 1'b1;
            q_r   <= '0;
            r_r   <= '0;
            tag_r <= op_tag;
            err_r <= ERR_TIMEOUT;
            state <= OUT;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            ov_r  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_ctrl.sv
// Randomised and directed bench for div_ctrl with a behavioural divider and a result scoreboard.
module tb_div_ctrl;
  localparam int WIDTH   = 32;
  localparam int FRAC    = 16;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n;

  div_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  div_ctrl #(
    .WIDTH  (WIDTH),
    .FRAC   (FRAC),
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic [3:0]  tag;
    logic [1:0]  err;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_starts = 0;
  int   lat = 20;
  bit   rnd_lat = 1'b0;
  bit   stale = 1'b0;
  bit   stuck = 1'b0;
  int   rdy_mode = 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Q16.16 quotient/remainder of the scaled numerator, truncating toward zero.
  function automatic void fx_div(input logic [31:0] n, input logic [31:0] d,
                                 output logic [31:0] q, output logic [31:0] r);
    longint num, den;
    num = longint'($signed(n)) * (longint'(1) <<< FRAC);
    den = longint'($signed(d));
    if (den == 0) begin
      q = '0;
      r = '0;
    end else begin
      q = 32'(num / den);
      r = 32'(num % den);
    end
  endfunction

  function automatic exp_t expect_of(input logic [31:0] n, input logic [31:0] d,
                                     input logic [3:0] tag, input bit stk);
    exp_t e;
    e.tag = tag;
    if (d == 32'd0) begin
      e.q   = n[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      e.r   = '0;
      e.err = 2'd1;
    end else if (stk) begin
      e.q   = '0;
      e.r   = '0;
      e.err = 2'd2;
    end else begin
      fx_div(n, d, e.q, e.r);
      e.err = 2'd0;
    end
    return e;
  endfunction

  // Behavioural divider: done is a level that stays high until the next start.
  // In stale mode it lingers two more cycles after a start, still showing the old result.
  initial begin
    int          since, cur_lat;
    bit          busy;
    logic [31:0] cn, cd, q, r;
    since = 0; cur_lat = 0; busy = 1'b0; cn = '0; cd = '0; q = '0; r = '0;
    bus.div_done = 1'b0;
    bus.div_q    = '0;
    bus.div_r    = '0;
    forever begin
      @(negedge clk);
      if (bus.div_start === 1'b1) begin
        n_starts++;
        cn = bus.div_n;
        cd = bus.div_d;
        since = 0;
        busy = 1'b1;
        cur_lat = rnd_lat ? int'($urandom_range(2, 30)) : lat;
        if (!stale) bus.div_done = 1'b0;
      end else if (busy) begin
        since++;
        if (since == 2) bus.div_done = 1'b0;
        if (!stuck && since >= cur_lat) begin
          fx_div(cn, cd, q, r);
          bus.div_q    = q;
          bus.div_r    = r;
          bus.div_done = 1'b1;
          busy = 1'b0;
        end
      end
    end
  end

  // Consumer: drives out_ready, scores every handshake and checks results hold while stalled.
  initial begin
    bit           pv;
    logic [127:0] pvals;
    exp_t         e;
    pv = 1'b0;
    pvals = '0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
        continue;
      end
      if (pv)
        chk("hold", 128'({bus.out_valid, bus.out_q, bus.out_r, bus.out_tag, bus.out_err}), pvals);
      case (rdy_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", 128'(sb.size()), 128'(1));
        else begin
          e = sb.pop_front();
          chk("out_q",   128'(bus.out_q),   128'(e.q));
          chk("out_r",   128'(bus.out_r),   128'(e.r));
          chk("out_tag", 128'(bus.out_tag), 128'(e.tag));
          chk("out_err", 128'(bus.out_err), 128'(e.err));
        end
      end
      pv = bus.out_valid && !bus.out_ready;
      pvals = 128'({1'b1, bus.out_q, bus.out_r, bus.out_tag, bus.out_err});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [31:0] n, input logic [31:0] d, input logic [3:0] tag);
    int w;
    w = 0;
    bus.in_valid = 1'b1;
    bus.in_n     = n;
    bus.in_d     = d;
    bus.in_tag   = tag;
    while (!bus.in_ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) chk("push_wait", 128'(w), 128'(0));
    else sb.push_back(expect_of(n, d, tag, stuck));
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_start(output int c);
    c = 0;
    while (bus.div_start !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic wait_out(output int c);
    c = 0;
    while (bus.out_valid !== 1'b1 && c < 300) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((sb.size() != 0 || bus.out_valid !== 1'b0) && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk("drain", 128'(c < 5000), 128'(1));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, 128'(bus.in_ready), 128'(0));
    chk({tag, "_out"},
        128'({bus.out_valid, bus.out_q, bus.out_r, bus.out_tag, bus.out_err}), 128'(0));
    chk({tag, "_div"}, 128'({bus.div_start, bus.div_n, bus.div_d}), 128'(0));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int          c, s;
    bit          seen;
    logic [31:0] n, d;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_n = '0;
    bus.in_d = '0;
    bus.in_tag = '0;

    tick(3);
    chk_reset_state("reset");
    rst_n = 1'b1;
    tick(1);
    chk("ready_after_reset", 128'(bus.in_ready), 128'(1));

    // 3.0 / 2.0 = 1.5 with a fixed 20-cycle divider
    rdy_mode = 1;
    push(32'h0003_0000, 32'h0002_0000, 4'd5);
    wait_start(c);
    chk("accept_to_issue", 128'(c + 1), 128'(2));
    chk("div_n", 128'(bus.div_n), 128'(32'h0003_0000));
    chk("div_d", 128'(bus.div_d), 128'(32'h0002_0000));
    wait_out(c);
    chk("done_to_out", 128'(c), 128'(lat + 1));
    chk("basic_q", 128'(bus.out_q), 128'(32'h0001_8000));
    chk("basic_tag", 128'(bus.out_tag), 128'(5));
    chk("basic_err", 128'(bus.out_err), 128'(0));
    chk("div_n_hold", 128'(bus.div_n), 128'(32'h0003_0000));
    drain();

    // divide by zero, negative and positive numerator
    s = n_starts;
    push(32'hFFFF_0000, 32'h0, 4'd9);
    wait_out(c);
    chk("divz_neg_q", 128'(bus.out_q), 128'(32'h8000_0000));
    chk("divz_r", 128'(bus.out_r), 128'(0));
    chk("divz_err", 128'(bus.out_err), 128'(1));
    drain();
    push(32'h0001_0000, 32'h0, 4'd10);
    drain();
    chk("divz_no_start", 128'(n_starts), 128'(s));

    // fill the FIFO behind a busy divider, then release in order
    rdy_mode = 0;
    push(32'h0001_0000, 32'h0001_0000, 4'd15);
    wait_start(c);
    chk("pre_start", 128'(c < 200), 128'(1));
    for (int i = 0; i < 4; i++) push(32'(i + 1) << 16, 32'h0002_0000, 4'(i));
    chk("full_ready", 128'(bus.in_ready), 128'(0));
    tick(30);
    chk("full_ready_held", 128'(bus.in_ready), 128'(0));
    chk("stalled_valid", 128'(bus.out_valid), 128'(1));
    rdy_mode = 2;
    push(32'h0005_0000, 32'h0002_0000, 4'd4);
    drain();

    // divider never answers: timeout, then a normal request
    rdy_mode = 1;
    stuck = 1'b1;
    push(32'h0001_0000, 32'h0001_0000, 4'd7);
    wait_start(c);
    wait_out(c);
    chk("timeout_cycles", 128'(c), 128'(TIMEOUT + 2));
    chk("timeout_err", 128'(bus.out_err), 128'(2));
    chk("timeout_q", 128'(bus.out_q), 128'(0));
    drain();
    stuck = 1'b0;
    push(32'h0002_0000, 32'h0001_0000, 4'd8);
    wait_start(c);
    wait_out(c);
    chk("after_timeout_q", 128'(bus.out_q), 128'(32'h0002_0000));
    chk("after_timeout_err", 128'(bus.out_err), 128'(0));
    drain();

    // done still high from the previous division must be ignored
    stale = 1'b1;
    lat = 6;
    push(32'h0005_0000, 32'h0001_0000, 4'd1);
    drain();
    push(32'h0001_0000, 32'h0004_0000, 4'd2);
    wait_start(c);
    wait_out(c);
    chk("stale_q", 128'(bus.out_q), 128'(32'h0000_4000));
    chk("stale_lat", 128'(c), 128'(lat + 1));
    drain();

    // reset in WAIT with a second request queued; the in-flight result must vanish
    lat = 20;
    push(32'h0007_0000, 32'h0002_0000, 4'd3);
    wait_start(c);
    push(32'h0001_0000, 32'h0001_0000, 4'd4);
    tick(3);
    rst_n = 1'b0;
    tick(1);
    chk_reset_state("mid_reset");
    rst_n = 1'b1;
    sb.delete();
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (bus.out_valid !== 1'b0 || bus.div_start !== 1'b0) seen = 1'b1;
    end
    chk("post_reset_quiet", 128'(seen), 128'(0));
    push(32'h0009_0000, 32'h0003_0000, 4'd6);
    wait_start(c);
    wait_out(c);
    chk("post_reset_q", 128'(bus.out_q), 128'(32'h0003_0000));
    chk("post_reset_tag", 128'(bus.out_tag), 128'(6));
    drain();
    stale = 1'b0;

    // random operands, latencies, gaps and back-pressure
    rdy_mode = 2;
    rnd_lat = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(int'($urandom_range(0, 3)));
      stale = 1'($urandom_range(0, 1));
      n = $urandom;
      d = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 16));
      push(n, d, 4'(i));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width, signed Q(WIDTH-FRAC).FRAC.
REQ-002 Parameter FRAC, default 16: fractional bits.
REQ-003 Parameter DEPTH, default 4: request FIFO entries, a power of 2 and >= 2.
REQ-004 Parameter TAG_W, default 4: request tag width.
REQ-005 Parameter TIMEOUT, default 64: max cycles waiting for div done.
REQ-006 clk  input  1  sole clock, all logic on rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 in_valid  input  1  request valid.
REQ-009 in_ready  output  1  request FIFO not full.
REQ-010 in_n  input  WIDTH  numerator.
REQ-011 in_d  input  WIDTH  denominator.
REQ-012 in_tag  input  TAG_W  request tag.
REQ-013 div_n  output  WIDTH  numerator to divider.
REQ-014 div_d  output  WIDTH  denominator to divider.
REQ-015 div_start  output  1  divider start pulse.
REQ-016 div_q  input  WIDTH  divider quotient.
REQ-017 div_r  input  WIDTH  divider remainder.
REQ-018 div_done  input  1  divider done level.
REQ-019 out_valid  output  1  result valid.
REQ-020 out_ready  input  1  consumer accepts result.
REQ-021 out_q  output  WIDTH  quotient.
REQ-022 out_r  output  WIDTH  remainder.
REQ-023 out_tag  output  TAG_W  tag of the request.
REQ-024 out_err  output  2  0 ok, 1 divide-by-zero, 2 timeout.

Function
REQ-025 A request is accepted on a cycle with in_valid && in_ready; it is pushed into the FIFO in order.
REQ-026 in_ready SHALL be 0 when the FIFO holds DEPTH entries, with no same-cycle pop bypass.
REQ-027 The FSM SHALL have states IDLE, ISSUE, ARM, WAIT and OUT.
- IDLE: FIFO non-empty -> pop the head into the operand register; d==0 -> OUT, otherwise -> ISSUE.
- ISSUE: div_start=1 for exactly one cycle -> ARM.
- ARM: one cycle with div_done ignored, masking a stale done from a prior operation -> WAIT.
- WAIT: div_done=1 -> capture div_q/div_r, err=0 -> OUT; timeout counter reaches TIMEOUT -> err=2, q=0, r=0 -> OUT.
- OUT: out_valid=1; out_ready=1 -> IDLE.
REQ-028 div_n/div_d SHALL hold the registered operands, stable from ISSUE until WAIT exits.
REQ-029 Divide-by-zero: the divider is not started; out_q=32'h7FFF_FFFF if n>=0 else 32'h8000_0000 (scaled to WIDTH); out_r=0; err=1.
REQ-030 out_q, out_r, out_tag and out_err SHALL be registered and held stable while out_valid && !out_ready.
REQ-031 Latency for a non-zero d with an idle controller: out_valid asserts 1 cycle after div_done is sampled in WAIT; accept-to-ISSUE is 2 cycles.
REQ-032 Simultaneous push and pop on a full FIFO is not possible (in_ready=0); on a non-full FIFO both occur and the count is unchanged.
REQ-033 FIFO pointers SHALL wrap modulo DEPTH; a count of DEPTH+1 distinguishes full from empty.
REQ-034 Only one division is outstanding at any time.

Reset
REQ-035 When rst_n=0 at a clock edge, the FSM SHALL go to IDLE and the FIFO SHALL empty, including mid-operation.
REQ-036 During reset: in_ready=0, div_start=0, out_valid=0, out_q=0, out_r=0, out_tag=0, out_err=0, div_n=0, div_d=0, timeout counter=0.
REQ-037 A result in flight from the divider after reset is discarded, because the ARM masking applies again on the next issue.

Structure
REQ-038 Package div_pkg SHALL hold the FSM state enum, the err code constants (ERR_OK, ERR_DIVZ, ERR_TIMEOUT) and the saturation constants.
REQ-039 The request FIFO SHALL be a sub-module named div_req_fifo (synchronous, parameterised by width and DEPTH).
REQ-040 The divider itself is external and is connected at the parent level.

Verification
REQ-041 n=0x0003_0000, d=0x0002_0000, tag=5, behavioural div with 20-cycle latency -> out_q=0x0001_8000, out_tag=5, err=0.
REQ-042 n=0xFFFF_0000 (-1.0), d=0 -> no div_start pulse; out_q=0x8000_0000, out_r=0, err=1.
REQ-043 Push 5 requests back-to-back with DEPTH=4 and the divider busy -> in_ready drops after 4 accepts; results emerge in order with tags 0..4.
REQ-044 div_done stuck at 0 -> err=2 exactly TIMEOUT cycles into WAIT; the next request completes normally.
REQ-045 div_done left high from the previous op, new request -> the stale done is ignored in ARM and the correct new quotient is returned.
REQ-046 rst_n low for 1 cycle during WAIT -> all outputs reset; a later request completes with the correct result.
